// File: rtl/ppm_slot_decoder.sv
// PPM slot decoder: samples the synchronised line once per slot tick and turns each
// frame of 2^BITS slots into a symbol (or an error) for the downstream byte assembler.
module ppm_slot_decoder #(
    parameter int BITS = 2,
    parameter int NSYM = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            slot_clk,
    input  logic            ppm_in,
    output logic [BITS-1:0] sym_data,
    output logic            sym_valid,
    output logic            sym_err,
    output logic            pkt_done,
    output logic            busy
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [BITS-1:0] LAST_SLOT = {BITS{1'b1}};
    localparam logic [7:0]      LAST_SYM  = 8'(NSYM - 1);

    state_t          state, state_n;
    logic            ppm_meta, ppm_s;
    logic            slot_clk_d;
    logic            tick;
    logic [BITS-1:0] slot_cnt, slot_cnt_n;
    logic [7:0]      sym_cnt, sym_cnt_n;
    logic [1:0]      hit_cnt, hit_cnt_n;
    logic [BITS-1:0] pos_reg, pos_reg_n;
    logic [BITS-1:0] sym_data_n;
    logic            sym_valid_n, sym_err_n, pkt_done_n;

    // slot_clk_d resets high so a slot clock already high at reset release is not a tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ppm_meta   <= 1'b0;
            ppm_s      <= 1'b0;
            slot_clk_d <= 1'b1;
        end else begin
            ppm_meta   <= ppm_in;
            ppm_s      <= ppm_meta;
            slot_clk_d <= slot_clk;
        end
    end

    assign tick = slot_clk & ~slot_clk_d;
    assign busy = (state != HUNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            slot_cnt  <= '0;
            sym_cnt   <= '0;
            hit_cnt   <= '0;
            pos_reg   <= '0;
            sym_data  <= '0;
            sym_valid <= 1'b0;
            sym_err   <= 1'b0;
            pkt_done  <= 1'b0;
        end else begin
            state     <= state_n;
            slot_cnt  <= slot_cnt_n;
            sym_cnt   <= sym_cnt_n;
            hit_cnt   <= hit_cnt_n;
            pos_reg   <= pos_reg_n;
            sym_data  <= sym_data_n;
            sym_valid <= sym_valid_n;
            sym_err   <= sym_err_n;
            pkt_done  <= pkt_done_n;
        end
    end

    always_comb begin
        state_n     = state;
        slot_cnt_n  = slot_cnt;
        sym_cnt_n   = sym_cnt;
        hit_cnt_n   = hit_cnt;
        pos_reg_n   = pos_reg;
        sym_data_n  = sym_data;
        sym_valid_n = 1'b0;
        sym_err_n   = 1'b0;
        pkt_done_n  = 1'b0;
        case (state)
            HUNT: begin
                if (tick && ppm_s) begin
                    state_n    = DATA;
                    slot_cnt_n = '0;
                    sym_cnt_n  = '0;
                    hit_cnt_n  = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (ppm_s) begin
                        pos_reg_n = slot_cnt;
                        hit_cnt_n = (hit_cnt == 2'd2) ? 2'd2 : hit_cnt + 2'd1;
                    end
                    if (slot_cnt == LAST_SLOT) begin
                        state_n = EMIT;
                    end else begin
                        slot_cnt_n = slot_cnt + BITS'(1);
                    end
                end
            end
            EMIT: begin
                // Exactly one pulse is a symbol; none or several is a bad frame that still counts.
                if (hit_cnt == 2'd1) begin
                    sym_data_n  = pos_reg;
                    sym_valid_n = 1'b1;
                end else begin
                    sym_data_n = '0;
                    sym_err_n  = 1'b1;
                end
                slot_cnt_n = '0;
                hit_cnt_n  = '0;
                sym_cnt_n  = sym_cnt + 8'd1;
                if (sym_cnt == LAST_SYM) begin
                    pkt_done_n = 1'b1;
                    state_n    = HUNT;
                end else begin
                    state_n = DATA;
                end
            end
            default: state_n = HUNT;
        endcase
    end

endmodule
